// File: rtl/dmem_map_pkg.sv
// Shared address map, STATUS bit layout and reset constants for the
// data-memory responder and its timer.
package dmem_map_pkg;

  // Region bases: RAM at the bottom of the map, one 16-byte peripheral page.
  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] PERIPH_BASE = 32'h1000_0000;

  // Register byte offsets inside the peripheral page.
  localparam logic [3:0] OFF_LED    = 4'h0;
  localparam logic [3:0] OFF_TCOUNT = 4'h4;
  localparam logic [3:0] OFF_TCMP   = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  // STATUS bit indices.
  localparam int ST_MATCH = 0;
  localparam int ST_ERR   = 1;
  localparam int ST_TEN   = 2;
  localparam int ST_IEN   = 3;

  // Reset values, sliced down to the configured widths by the users.
  localparam logic [31:0] LED_RESET    = 32'h0000_0000;
  localparam logic [31:0] TCOUNT_RESET = 32'h0000_0000;
  localparam logic [31:0] TCMP_RESET   = 32'hFFFF_FFFF;

  // Decoded target of the current access.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_TCOUNT,
    SEL_TCMP,
    SEL_STATUS
  } sel_e;

endpackage

// File: rtl/dmem_timer.sv
// Free-running timer: counter, compare register and the sticky MATCH flag.
// A core write to the counter overrides that cycle's increment; a new match
// overrides a same-cycle write-one-to-clear of MATCH.
module dmem_timer
  import dmem_map_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               count_we,
  input  logic               cmp_we,
  input  logic               match_clr,
  input  logic [TIMER_W-1:0] wdata,
  output logic [TIMER_W-1:0] count,
  output logic [TIMER_W-1:0] cmp,
  output logic               match
);

  logic hit;

  // A match is judged on the pre-edge counter and compare values.
  assign hit = en && (count == cmp);

  // Counter, compare and MATCH registers with write/increment priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= TCOUNT_RESET[TIMER_W-1:0];
      cmp   <= TCMP_RESET[TIMER_W-1:0];
      match <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
      end else if (en) begin
        count <= count + 1'b1;
      end
      if (cmp_we) begin
        cmp <= wdata;
      end
      if (hit) begin
        match <= 1'b1;
      end else if (match_clr) begin
        match <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dmem_bus_responder.sv
// Responder for the core's data-memory port: word RAM plus a small
// peripheral page (LEDs, timer, STATUS).
//
// Bus semantics: there is no handshake. READ and WRITE are single-cycle
// strobes qualified by DIR_DMEM; the responder is always ready. A read is
// answered combinationally in the same cycle, a write commits at the next
// rising edge of CLK. An access is illegal when it is misaligned, unmapped,
// or has READ and WRITE high together; it then returns 0, changes nothing
// and raises the sticky ERR flag at the next edge.
module dmem_bus_responder
  import dmem_map_pkg::*;
#(
  parameter int RAM_WORDS = 1024,
  parameter int LED_W     = 8,
  parameter int TIMER_W   = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [31:0]      DIR_DMEM,
  input  logic [31:0]      DATA_WRITE_DMEM,
  input  logic             READ,
  input  logic             WRITE,
  output logic [31:0]      DATA_READ_DMEM,
  output logic [LED_W-1:0] LEDS,
  output logic             TIMER_IRQ,
  output logic             BUS_ERR
);

  localparam int RAM_AW = $clog2(RAM_WORDS);

  sel_e               sel;
  logic               misaligned;
  logic               conflict;
  logic               legal;
  logic               legal_rd;
  logic               legal_wr;
  logic               illegal;
  logic [RAM_AW-1:0]  ram_idx;
  logic [31:0]        ram [RAM_WORDS];
  logic [31:0]        rd_word;
  logic               err;
  logic               ten;
  logic               ien;
  logic               match;
  logic [TIMER_W-1:0] tcount;
  logic [TIMER_W-1:0] tcmp;
  logic               wr_ram;
  logic               wr_led;
  logic               wr_tcount;
  logic               wr_tcmp;
  logic               wr_status;

  assign ram_idx    = DIR_DMEM[RAM_AW+1:2];
  assign misaligned = |DIR_DMEM[1:0];
  assign conflict   = READ & WRITE;
  assign legal      = !misaligned && !conflict && (sel != SEL_NONE);
  assign legal_rd   = READ & legal;
  assign legal_wr   = WRITE & legal;
  assign illegal    = (READ | WRITE) & ~legal;

  assign wr_ram    = legal_wr && (sel == SEL_RAM);
  assign wr_led    = legal_wr && (sel == SEL_LED);
  assign wr_tcount = legal_wr && (sel == SEL_TCOUNT);
  assign wr_tcmp   = legal_wr && (sel == SEL_TCMP);
  assign wr_status = legal_wr && (sel == SEL_STATUS);

  // Region/register decode from the byte address.
  always_comb begin
    sel = SEL_NONE;
    if (DIR_DMEM[31:RAM_AW+2] == '0) begin
      sel = SEL_RAM;
    end else if (DIR_DMEM[31:4] == PERIPH_BASE[31:4]) begin
      case ({DIR_DMEM[3:2], 2'b00})
        OFF_LED:    sel = SEL_LED;
        OFF_TCOUNT: sel = SEL_TCOUNT;
        OFF_TCMP:   sel = SEL_TCMP;
        OFF_STATUS: sel = SEL_STATUS;
        default:    sel = SEL_NONE;
      endcase
    end
  end

  // Read mux; narrower registers are zero-extended.
  always_comb begin
    rd_word = '0;
    case (sel)
      SEL_RAM:    rd_word = ram[ram_idx];
      SEL_LED:    rd_word = 32'(LEDS);
      SEL_TCOUNT: rd_word = 32'(tcount);
      SEL_TCMP:   rd_word = 32'(tcmp);
      SEL_STATUS: begin
        rd_word[ST_MATCH] = match;
        rd_word[ST_ERR]   = err;
        rd_word[ST_TEN]   = ten;
        rd_word[ST_IEN]   = ien;
      end
      default:    rd_word = '0;
    endcase
  end

  // RAM has no reset, so the output is forced to 0 while in reset.
  assign DATA_READ_DMEM = (RESET_N && legal_rd) ? rd_word : 32'h0;

  // Word RAM; the read above sees pre-edge contents on read-during-write.
  always_ff @(posedge CLK) begin
    if (wr_ram) begin
      ram[ram_idx] <= DATA_WRITE_DMEM;
    end
  end

  // LED register and STATUS ERR/TEN/IEN; a new error beats a W1C of ERR.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      LEDS <= LED_RESET[LED_W-1:0];
      err  <= 1'b0;
      ten  <= 1'b0;
      ien  <= 1'b0;
    end else begin
      if (wr_led) begin
        LEDS <= DATA_WRITE_DMEM[LED_W-1:0];
      end
      if (wr_status) begin
        ten <= DATA_WRITE_DMEM[ST_TEN];
        ien <= DATA_WRITE_DMEM[ST_IEN];
      end
      if (illegal) begin
        err <= 1'b1;
      end else if (wr_status && DATA_WRITE_DMEM[ST_ERR]) begin
        err <= 1'b0;
      end
    end
  end

  dmem_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk       (CLK),
    .reset_n   (RESET_N),
    .en        (ten),
    .count_we  (wr_tcount),
    .cmp_we    (wr_tcmp),
    .match_clr (wr_status && DATA_WRITE_DMEM[ST_MATCH]),
    .wdata     (DATA_WRITE_DMEM[TIMER_W-1:0]),
    .count     (tcount),
    .cmp       (tcmp),
    .match     (match)
  );

  assign TIMER_IRQ = match & ien;
  assign BUS_ERR   = err;

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Bench for dmem_bus_responder: directed map/timer/reset scenarios followed
// by random traffic, checked against a behavioural model of the memory map.
module tb_dmem_bus_responder;

  localparam int RAM_WORDS = 1024;
  localparam int LED_W     = 8;
  localparam int TIMER_W   = 8;

  localparam logic [31:0] A_LED    = 32'h1000_0000;
  localparam logic [31:0] A_TCOUNT = 32'h1000_0004;
  localparam logic [31:0] A_TCMP   = 32'h1000_0008;
  localparam logic [31:0] A_STATUS = 32'h1000_000C;

  // ---------------- clock / reset / DUT ----------------
  logic             CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic [31:0]      DIR_DMEM = '0;
  logic [31:0]      DATA_WRITE_DMEM = '0;
  logic             READ = 1'b0;
  logic             WRITE = 1'b0;
  logic [31:0]      DATA_READ_DMEM;
  logic [LED_W-1:0] LEDS;
  logic             TIMER_IRQ;
  logic             BUS_ERR;

  always #5 CLK = ~CLK;

  dmem_bus_responder #(
    .RAM_WORDS (RAM_WORDS),
    .LED_W     (LED_W),
    .TIMER_W   (TIMER_W)
  ) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .DIR_DMEM        (DIR_DMEM),
    .DATA_WRITE_DMEM (DATA_WRITE_DMEM),
    .READ            (READ),
    .WRITE           (WRITE),
    .DATA_READ_DMEM  (DATA_READ_DMEM),
    .LEDS            (LEDS),
    .TIMER_IRQ       (TIMER_IRQ),
    .BUS_ERR         (BUS_ERR)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  bit          mon_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [int];
  logic [7:0]  m_leds, m_tcount, m_tcmp;
  bit          m_match, m_err, m_ten, m_ien;

  function automatic void model_reset();
    m_leds = 8'h00; m_tcount = 8'h00; m_tcmp = 8'hFF;
    m_match = 0; m_err = 0; m_ten = 0; m_ien = 0;
  endfunction

  // 0 unmapped, 1 RAM, 2 LED, 3 TCOUNT, 4 TCMP, 5 STATUS
  function automatic int region(input logic [31:0] a);
    if (a < 32'(RAM_WORDS * 4)) return 1;
    if (a >= 32'h1000_0000 && a < 32'h1000_0010) return 2 + int'((a - 32'h1000_0000) / 4);
    return 0;
  endfunction

  function automatic bit model_legal(input bit rd, input bit wr, input logic [31:0] a);
    return (rd != wr) && (a % 4 == 0) && (region(a) != 0);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (region(a))
      1: return m_mem.exists(int'(a / 4)) ? m_mem[int'(a / 4)] : 32'h0;
      2: return {24'h0, m_leds};
      3: return {24'h0, m_tcount};
      4: return {24'h0, m_tcmp};
      5: return {28'h0, m_ien, m_ten, m_err, m_match};
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of the memory map's behaviour, from pre-edge state.
  function automatic void model_step(input bit rd, input bit wr, input logic [31:0] a,
                                     input logic [31:0] d);
    bit         legal, illegal, hit;
    logic [7:0] nxt_count;
    int         r;
    r         = region(a);
    legal     = model_legal(rd, wr, a);
    illegal   = (rd || wr) && !legal;
    hit       = m_ten && (m_tcount == m_tcmp);
    nxt_count = m_ten ? m_tcount + 8'd1 : m_tcount;
    if (legal && wr) begin
      case (r)
        1: m_mem[int'(a / 4)] = d;
        2: m_leds = d[7:0];
        3: nxt_count = d[7:0];
        4: m_tcmp = d[7:0];
        5: begin
          if (d[0]) m_match = 0;
          if (d[1]) m_err = 0;
          m_ten = d[2];
          m_ien = d[3];
        end
        default: ;
      endcase
    end
    if (hit) m_match = 1;
    if (illegal) m_err = 1;
    m_tcount = nxt_count;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1; drives one bus cycle and returns at the next posedge+1.
  task automatic bus_cycle(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input bit use_const, input logic [31:0] const_val);
    READ = rd; WRITE = wr; DIR_DMEM = a; DATA_WRITE_DMEM = d;
    if (rd) exp_q.push_back(use_const ? const_val
                                      : (model_legal(rd, wr, a) ? model_read(a) : 32'h0));
    @(posedge CLK);
    model_step(rd, wr, a, d);
    #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic wr_bus(input logic [31:0] a, input logic [31:0] d);
    bus_cycle(1'b0, 1'b1, a, d, 1'b0, 32'h0);
  endtask

  task automatic rd_exp(input logic [31:0] a, input logic [31:0] v);
    bus_cycle(1'b1, 1'b0, a, 32'h0, 1'b1, v);
  endtask

  task automatic rd_model(input logic [31:0] a);
    bus_cycle(1'b1, 1'b0, a, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic idle();
    bus_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    logic [31:0] e;
    if (mon_en) begin
      if (READ) begin
        if (exp_q.size() == 0) begin
          chk("rd_underflow", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", DATA_READ_DMEM, e);
        end
      end
      chk("leds", 32'(LEDS), {24'h0, m_leds});
      chk("timer_irq", 32'(TIMER_IRQ), 32'(m_match & m_ien));
      chk("bus_err", 32'(BUS_ERR), 32'(m_err));
    end
  end

  // Watchdog: the run is purely cycle-driven, so this only trips on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] unm [4];
    unm[0] = 32'h1000_0010;
    unm[1] = 32'(RAM_WORDS * 4);
    unm[2] = 32'h2000_0000;
    unm[3] = 32'hFFFF_FFFC;
    model_reset();

    // Reset state, with a read of TCMP held high to check the output gating.
    READ = 1'b1; DIR_DMEM = A_TCMP;
    #3;
    chk("rst_leds", 32'(LEDS), 32'h0);
    chk("rst_irq", 32'(TIMER_IRQ), 32'h0);
    chk("rst_err", 32'(BUS_ERR), 32'h0);
    chk("rst_rdata", DATA_READ_DMEM, 32'h0);
    #9;
    READ = 1'b0; RESET_N = 1'b1;
    @(posedge CLK); #1;
    mon_en = 1'b1;
    rd_exp(A_TCMP, 32'h0000_00FF);
    rd_exp(A_STATUS, 32'h0);

    // RAM write/read, neighbouring word intact.
    wr_bus(32'h10, 32'hDEAD_BEEF);
    rd_exp(32'h10, 32'hDEAD_BEEF);
    wr_bus(32'h14, 32'h1234_5678);
    rd_exp(32'h14, 32'h1234_5678);
    rd_exp(32'h10, 32'hDEAD_BEEF);

    // Illegal accesses.
    wr_bus(32'h12, 32'hFFFF_FFFF);
    chk("err_misaligned", 32'(BUS_ERR), 32'h1);
    rd_exp(32'h10, 32'hDEAD_BEEF);
    rd_exp(32'h2000_0000, 32'h0);
    wr_bus(A_STATUS, 32'h2);
    chk("err_w1c", 32'(BUS_ERR), 32'h0);
    bus_cycle(1'b1, 1'b1, 32'h14, 32'hAAAA_AAAA, 1'b1, 32'h0);
    chk("err_rdwr", 32'(BUS_ERR), 32'h1);
    rd_exp(32'h14, 32'h1234_5678);
    wr_bus(A_STATUS, 32'h2);

    // LED register keeps only its low bits.
    wr_bus(A_LED, 32'hFFFF_FF5A);
    rd_exp(A_LED, 32'h0000_005A);
    chk("leds_value", 32'(LEDS), 32'h5A);

    // Timer match with IRQ enabled.
    wr_bus(A_TCMP, 32'd5);
    wr_bus(A_TCOUNT, 32'd0);
    wr_bus(A_STATUS, 32'hC);
    for (int i = 0; i <= 5; i++) begin
      rd_exp(A_TCOUNT, 32'(i));
      chk("irq_rise", 32'(TIMER_IRQ), (i == 5) ? 32'h1 : 32'h0);
    end
    rd_exp(A_STATUS, 32'hD);

    // Misaligned STATUS write must not clear MATCH.
    wr_bus(32'h1000_000E, 32'h1);
    rd_exp(A_STATUS, 32'hF);
    wr_bus(A_STATUS, 32'h7);
    rd_exp(A_STATUS, 32'h4);
    chk("irq_cleared", 32'(TIMER_IRQ), 32'h0);

    // Write beats increment; new match beats W1C.
    wr_bus(A_TCMP, 32'd102);
    wr_bus(A_TCOUNT, 32'd100);
    rd_exp(A_TCOUNT, 32'd100);
    idle();
    wr_bus(A_STATUS, 32'h5);
    rd_exp(A_STATUS, 32'h5);
    chk("irq_ien_off", 32'(TIMER_IRQ), 32'h0);

    // Wrap at 2^TIMER_W-1.
    wr_bus(A_STATUS, 32'h5);
    wr_bus(A_TCOUNT, 32'hFFFF_FFFF);
    rd_exp(A_TCOUNT, 32'h0000_00FF);
    rd_exp(A_TCOUNT, 32'h0000_0000);

    // Build up IRQ and ERR, then reset between edges.
    wr_bus(A_STATUS, 32'h3);
    wr_bus(A_TCMP, 32'h22);
    wr_bus(A_TCOUNT, 32'h20);
    wr_bus(A_STATUS, 32'hC);
    idle(); idle(); idle();
    chk("pre_rst_irq", 32'(TIMER_IRQ), 32'h1);
    rd_exp(32'h3, 32'h0);
    chk("pre_rst_err", 32'(BUS_ERR), 32'h1);

    mon_en = 1'b0;
    READ = 1'b1; DIR_DMEM = 32'h10;
    #1 RESET_N = 1'b0;
    #1;
    chk("mid_rst_leds", 32'(LEDS), 32'h0);
    chk("mid_rst_irq", 32'(TIMER_IRQ), 32'h0);
    chk("mid_rst_err", 32'(BUS_ERR), 32'h0);
    chk("mid_rst_rdata", DATA_READ_DMEM, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    READ = 1'b0; RESET_N = 1'b1;
    model_reset();
    @(posedge CLK); #1;
    mon_en = 1'b1;
    rd_exp(A_TCOUNT, 32'h0);
    rd_exp(A_TCMP, 32'hFF);
    rd_exp(A_STATUS, 32'h0);
    rd_exp(A_LED, 32'h0);
    rd_exp(32'h10, 32'hDEAD_BEEF);
    rd_exp(32'h14, 32'h1234_5678);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      int          k;
      bit          r;
      logic [31:0] a, d;
      k = $urandom_range(0, 10);
      r = 1'($urandom_range(0, 1));
      d = $urandom();
      a = ($urandom_range(0, 7) == 0) ? 32'((RAM_WORDS - 1) * 4) : 32'($urandom_range(0, 15) * 4);
      case (k)
        0, 1: wr_bus(a, d);
        2, 3: if (m_mem.exists(int'(a / 4))) rd_model(a); else wr_bus(a, d);
        4:    wr_bus(A_LED + 32'($urandom_range(0, 3) * 4), d);
        5, 6: rd_model(A_LED + 32'($urandom_range(0, 3) * 4));
        7:    bus_cycle(r, !r, a + 32'($urandom_range(1, 3)), d, 1'b0, 32'h0);
        8:    bus_cycle(r, !r, unm[$urandom_range(0, 3)], d, 1'b0, 32'h0);
        9:    bus_cycle(1'b1, 1'b1, a, d, 1'b0, 32'h0);
        default: idle();
      endcase
    end

    idle();
    chk("q_drain", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
